// File: rtl/mont_exp_pkg.sv
// Shared types for the Montgomery modular exponentiation sequencer.
// Imported by the controller top and its exponent bit scanner.
package mont_exp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TO_MONT,
      SQUARE,
      MULT,
      FROM_MONT,
      DONE
   } state_e;

   typedef enum logic {
      PH_ISSUE,
      PH_WAIT
   } phase_e;

   // Index width for an exponent of ew bits, never narrower than 1.
   function automatic int idx_width(input int ew);
      return (ew > 1) ? $clog2(ew) : 1;
   endfunction

endpackage

// File: rtl/mont_exp_ctrl_scanner.sv
// Exponent bit scanner: MSB-first shift register plus bit index counter.
// cur_bit_o is e[idx]; last_bit_o flags idx == 0.
module exp_bit_scanner
   import mont_exp_pkg::*;
#(
   parameter int E_WIDTH = 1024
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load_i,
   input  logic               advance_i,
   input  logic [E_WIDTH-1:0] e_i,
   output logic               cur_bit_o,
   output logic               last_bit_o
);

   localparam int IDX_W = idx_width(E_WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(E_WIDTH - 1);

   logic [E_WIDTH-1:0] sr_q;
   logic [IDX_W-1:0]   idx_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr_q  <= '0;
         idx_q <= '0;
      end else if (load_i) begin
         sr_q  <= e_i;
         idx_q <= IDX_TOP;
      end else if (advance_i) begin
         sr_q  <= sr_q << 1;
         idx_q <= idx_q - IDX_W'(1);
      end
   end

   assign cur_bit_o  = sr_q[E_WIDTH-1];
   assign last_bit_o = (idx_q == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod m
// around one shared, externally instantiated Montgomery multiplier.
module mont_exp_ctrl
   import mont_exp_pkg::*;
#(
   parameter int WIDTH   = 1024,
   parameter int E_WIDTH = 1024
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [E_WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0]   in_m,
   input  logic [WIDTH-1:0]   in_r,
   input  logic [WIDTH-1:0]   in_r2,
   output logic [WIDTH-1:0]   result,
   output logic               done,
   output logic               busy,
   output logic               mont_start,
   output logic [WIDTH-1:0]   mont_a,
   output logic [WIDTH-1:0]   mont_b,
   output logic [WIDTH-1:0]   mont_m,
   input  logic [WIDTH-1:0]   mont_result,
   input  logic               mont_done
);

   state_e state_q;
   phase_e ph_q;

   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] r2_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] xt_q;
   logic [WIDTH-1:0] res_q;
   logic             done_q;
   logic             busy_q;
   logic             mstart_q;

   logic in_mul;
   logic accept;
   logic capture;
   logic advance;
   logic cur_bit;
   logic last_bit;

   assign in_mul  = state_q inside {TO_MONT, SQUARE, MULT, FROM_MONT};
   assign accept  = start && (state_q == IDLE || state_q == DONE);
   assign capture = in_mul && ph_q == PH_WAIT && mont_done;

   // Index steps down only when leaving a bit for good: after its
   // square when the bit is 0, or after its multiply when it is 1.
   assign advance = capture && !last_bit &&
                    (state_q == MULT || (state_q == SQUARE && !cur_bit));

   exp_bit_scanner #(
      .E_WIDTH (E_WIDTH)
   ) u_scan (
      .clk        (clk),
      .resetn     (resetn),
      .load_i     (accept),
      .advance_i  (advance),
      .e_i        (in_e),
      .cur_bit_o  (cur_bit),
      .last_bit_o (last_bit)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         ph_q     <= PH_ISSUE;
         x_q      <= '0;
         m_q      <= '0;
         r2_q     <= '0;
         acc_q    <= '0;
         xt_q     <= '0;
         res_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         mstart_q <= 1'b0;
      end else begin
         mstart_q <= 1'b0;
         if (accept) begin
            x_q     <= in_x;
            m_q     <= in_m;
            r2_q    <= in_r2;
            acc_q   <= in_r;
            state_q <= TO_MONT;
            ph_q    <= PH_ISSUE;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
         end else if (in_mul && ph_q == PH_ISSUE) begin
            mstart_q <= 1'b1;
            ph_q     <= PH_WAIT;
         end else if (capture) begin
            // Next multiply is issued straight out of the capture edge.
            mstart_q <= 1'b1;
            unique case (state_q)
               TO_MONT: begin
                  xt_q    <= mont_result;
                  state_q <= SQUARE;
               end
               SQUARE: begin
                  acc_q <= mont_result;
                  if (cur_bit)
                     state_q <= MULT;
                  else if (last_bit)
                     state_q <= FROM_MONT;
                  else
                     state_q <= SQUARE;
               end
               MULT: begin
                  acc_q   <= mont_result;
                  state_q <= last_bit ? FROM_MONT : SQUARE;
               end
               FROM_MONT: begin
                  res_q    <= mont_result;
                  state_q  <= DONE;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  mstart_q <= 1'b0;
               end
               default: begin
                  state_q  <= IDLE;
                  mstart_q <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      mont_a = '0;
      mont_b = '0;
      mont_m = m_q;
      unique case (state_q)
         IDLE: mont_m = '0;
         TO_MONT: begin
            mont_a = x_q;
            mont_b = r2_q;
         end
         SQUARE: begin
            mont_a = acc_q;
            mont_b = acc_q;
         end
         MULT: begin
            mont_a = acc_q;
            mont_b = xt_q;
         end
         FROM_MONT: begin
            mont_a = acc_q;
            mont_b = WIDTH'(1);
         end
         default: ;
      endcase
   end

   assign result     = res_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign mont_start = mstart_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: directed 8-bit cases plus random 1024-bit runs
// against a golden modular exponentiation and a bit-serial Montgomery model.
module tb_mont_exp_ctrl;

   localparam int BUDGET = 2000;

   logic clk;
   logic resetn;

   logic        st8;
   logic [7:0]  x8, e8, m8, r8, r28;
   logic [7:0]  res8, a8, b8, mm8, mr8;
   logic        done8, busy8, ms8, md8, mdone8, inj8;

   logic          stk;
   logic [1023:0] xk, mk, rk, r2k;
   logic [15:0]   ek;
   logic [1023:0] resk, ak, bk, mmk, mrk;
   logic          donek, busyk, msk, mdk, mdonek;

   int checks = 0;
   int errors = 0;
   int L8 = 0, Lk = 0;
   int rem8 = -1, remk = -1;
   int pulses8 = 0, pulsesk = 0;
   logic [1023:0] pend8, pendk;

   assign md8 = mdone8 | inj8;
   assign mdk = mdonek;

   mont_exp_ctrl #(.WIDTH(8), .E_WIDTH(8)) u_d8 (
      .clk         (clk),
      .resetn      (resetn),
      .start       (st8),
      .in_x        (x8),
      .in_e        (e8),
      .in_m        (m8),
      .in_r        (r8),
      .in_r2       (r28),
      .result      (res8),
      .done        (done8),
      .busy        (busy8),
      .mont_start  (ms8),
      .mont_a      (a8),
      .mont_b      (b8),
      .mont_m      (mm8),
      .mont_result (mr8),
      .mont_done   (md8)
   );

   mont_exp_ctrl #(.WIDTH(1024), .E_WIDTH(16)) u_dk (
      .clk         (clk),
      .resetn      (resetn),
      .start       (stk),
      .in_x        (xk),
      .in_e        (ek),
      .in_m        (mk),
      .in_r        (rk),
      .in_r2       (r2k),
      .result      (resk),
      .done        (donek),
      .busy        (busyk),
      .mont_start  (msk),
      .mont_a      (ak),
      .mont_b      (bk),
      .mont_m      (mmk),
      .mont_result (mrk),
      .mont_done   (mdk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // a*b*2^-w mod m, for a, b < m and m odd.
   function automatic logic [1023:0] mmul(input logic [1023:0] a,
                                          input logic [1023:0] b,
                                          input logic [1023:0] m,
                                          input int w);
      logic [1025:0] t;
      t = '0;
      for (int i = 0; i < w; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, m};
         t = t >> 1;
      end
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      return t[1023:0];
   endfunction

   // Right-to-left binary exponentiation with plain modular arithmetic.
   function automatic logic [1023:0] modexp(input logic [1023:0] x,
                                            input logic [15:0] e,
                                            input logic [1023:0] m);
      logic [2047:0] acc, base, mod;
      mod  = {1024'b0, m};
      acc  = 2048'(1) % mod;
      base = {1024'b0, x} % mod;
      for (int i = 0; i < 16; i++) begin
         if (e[i]) acc = (acc * base) % mod;
         base = (base * base) % mod;
      end
      return acc[1023:0];
   endfunction

   // Multiplier models: result ready L cycles after the start cycle.
   always @(negedge clk) begin
      mdone8 = 1'b0;
      if (ms8) begin
         pend8 = mmul(1024'(a8), 1024'(b8), 1024'(mm8), 8);
         rem8  = L8;
         pulses8++;
      end
      if (rem8 == 0) begin
         mdone8 = 1'b1;
         mr8    = pend8[7:0];
      end
      if (rem8 >= 0) rem8--;
   end

   always @(negedge clk) begin
      mdonek = 1'b0;
      if (msk) begin
         pendk = mmul(ak, bk, mmk, 1024);
         remk  = Lk;
         pulsesk++;
      end
      if (remk == 0) begin
         mdonek = 1'b1;
         mrk    = pendk;
      end
      if (remk >= 0) remk--;
   end

   task automatic chk(input string tag, input logic [1023:0] obs,
                      input logic [1023:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] e,
                       input int lat, input bit perturb, output int n);
      L8      = lat;
      pulses8 = 0;
      @(negedge clk);
      x8  = x;
      e8  = e;
      m8  = 8'hF1;
      r8  = 8'h0F;
      r28 = 8'hE1;
      st8 = 1'b1;
      @(negedge clk);
      st8  = 1'b0;
      inj8 = perturb;
      if (perturb) begin
         x8 = 8'hAA;
         e8 = 8'h55;
      end
      n = 0;
      while (!done8 && n < BUDGET) begin
         @(negedge clk);
         n++;
         inj8 = 1'b0;
         if (perturb) st8 = (n == 2);
      end
      st8 = 1'b0;
   endtask

   initial begin
      int n;
      logic [1024:0] rr;
      logic [2047:0] p;
      logic [1023:0] expv;
      int exp_n;

      resetn = 1'b0;
      st8 = 1'b0; x8 = '0; e8 = '0; m8 = '0; r8 = '0; r28 = '0;
      inj8 = 1'b0; mdone8 = 1'b0; mr8 = '0;
      stk = 1'b0; xk = '0; ek = '0; mk = '0; rk = '0; r2k = '0;
      mdonek = 1'b0; mrk = '0;
      repeat (2) @(negedge clk);

      chk("rst_result", 1024'(res8), 1024'(0));
      chk("rst_done",   1024'(done8), 1024'(0));
      chk("rst_busy",   1024'(busy8), 1024'(0));
      chk("rst_mstart", 1024'(ms8), 1024'(0));
      chk("rst_ops",    1024'({a8, b8, mm8}), 1024'(0));
      chk("rst_k_done", 1024'({donek, busyk, msk}), 1024'(0));
      resetn = 1'b1;
      @(negedge clk);

      // Scenario 1
      run8(8'h05, 8'h03, 3, 1'b0, n);
      chk("s1_done",   1024'(done8), 1024'(1));
      chk("s1_result", 1024'(res8), 1024'(8'h7D));
      chk("s1_pulses", 1024'(pulses8), 1024'(12));
      chk("s1_lat",    1024'(n), 1024'(49));
      chk("s1_busy",   1024'(busy8), 1024'(0));

      // Scenario 2
      run8(8'h02, 8'hFF, 0, 1'b0, n);
      chk("s2_result", 1024'(res8), 1024'(8'hE9));
      chk("s2_pulses", 1024'(pulses8), 1024'(18));
      chk("s2_lat",    1024'(n), 1024'(19));

      // Scenario 3
      run8(8'h05, 8'h00, 2, 1'b0, n);
      chk("s3_result", 1024'(res8), 1024'(8'h01));
      chk("s3_pulses", 1024'(pulses8), 1024'(10));
      chk("s3_lat",    1024'(n), 1024'(31));
      run8(8'h00, 8'h01, 1, 1'b0, n);
      chk("s3_zero",   1024'(res8), 1024'(8'h00));
      chk("s3_zpulse", 1024'(pulses8), 1024'(11));

      // Scenario 4: spurious done in ISSUE, start during WAIT, inputs change
      run8(8'h05, 8'h03, 3, 1'b1, n);
      chk("s4_result", 1024'(res8), 1024'(8'h7D));
      chk("s4_pulses", 1024'(pulses8), 1024'(12));
      chk("s4_lat",    1024'(n), 1024'(49));

      // Scenario 5: reset mid-SQUARE
      L8 = 3;
      @(negedge clk);
      x8 = 8'h05; e8 = 8'h03; st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (7) @(negedge clk);
      chk("s5_busy_pre", 1024'(busy8), 1024'(1));
      resetn = 1'b0;
      #1;
      chk("s5_rst_res",  1024'(res8), 1024'(0));
      chk("s5_rst_flag", 1024'({done8, busy8, ms8}), 1024'(0));
      chk("s5_rst_ops",  1024'({a8, b8, mm8}), 1024'(0));
      @(negedge clk);
      resetn  = 1'b1;
      pulses8 = 0;
      repeat (20) @(negedge clk);
      chk("s5_quiet",   1024'(pulses8), 1024'(0));
      chk("s5_idle",    1024'({done8, busy8}), 1024'(0));
      run8(8'h05, 8'h03, 3, 1'b0, n);
      chk("s5_result",  1024'(res8), 1024'(8'h7D));
      chk("s5_done",    1024'(done8), 1024'(1));

      // Scenario 6: random 1024-bit runs, back to back
      for (int k = 0; k < 100; k++) begin
         for (int i = 0; i < 32; i++) begin
            mk[i*32 +: 32] = $urandom();
            xk[i*32 +: 32] = $urandom();
         end
         mk[1023] = 1'b1;
         mk[0]    = 1'b1;
         xk = xk % mk;
         ek = 16'($urandom());
         rr = {1'b1, 1024'b0} % {1'b0, mk};
         rk = rr[1023:0];
         p  = ({1024'b0, rk} * {1024'b0, rk}) % {1024'b0, mk};
         r2k = p[1023:0];
         expv  = modexp(xk, ek, mk);
         Lk    = int'($urandom_range(0, 3));
         exp_n = (2 + 16 + $countones(ek)) * (Lk + 1) + 1;
         pulsesk = 0;
         @(negedge clk);
         stk = 1'b1;
         @(negedge clk);
         stk = 1'b0;
         n = 0;
         while (!donek && n < BUDGET) begin
            @(negedge clk);
            n++;
         end
         chk($sformatf("r%0d_done", k), 1024'(donek), 1024'(1));
         chk($sformatf("r%0d_res", k), resk, expv);
         chk($sformatf("r%0d_pulses", k), 1024'(pulsesk),
             1024'(2 + 16 + $countones(ek)));
         chk($sformatf("r%0d_lat", k), 1024'(n), 1024'(exp_n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
